async_fifo_wr_arb: RTL
======================

ASYNC_FIFO_WR_ARB -- requirements
Module: async_fifo_wr_arb

Interface
REQ-001 SHALL have parameter ASIZE, default 4: FIFO address width; depth is 2^ASIZE.
REQ-002 SHALL have parameter DSIZE, default 32: data width.
REQ-003 SHALL have parameter NREQ, default 4: number of requesters, range 2..8.
REQ-004 SHALL have port wclk, input, 1: write-domain clock.
REQ-005 SHALL have port wrst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, NREQ: per-requester beat valid.
REQ-007 SHALL have port req_last, input, NREQ: per-requester last beat of burst.
REQ-008 SHALL have port req_data, input, NREQ*DSIZE: requester i occupies bits [i*DSIZE +: DSIZE].
REQ-009 SHALL have port req_ready, output, NREQ: per-requester beat accept.
REQ-010 SHALL have port wq2_rptr, input, ASIZE+1: Gray read pointer, already synchronized into wclk.
REQ-011 SHALL have port wen, output, 1: FIFO RAM write enable.
REQ-012 SHALL have port waddr, output, ASIZE: FIFO RAM write address.
REQ-013 SHALL have port wdata, output, DSIZE: FIFO RAM write data.
REQ-014 SHALL have port wptr, output, ASIZE+1: registered Gray write pointer, sent to the read-side synchronizer.
REQ-015 SHALL have port wfull, output, 1: registered full flag.
REQ-016 SHALL have port wlevel, output, ASIZE+1: registered occupancy estimate, range 0..2^ASIZE.
REQ-017 SHALL have port grant_id, output, 3: index of the locked requester; valid while busy=1.
REQ-018 SHALL have port busy, output, 1: high while a burst is locked.

Function
REQ-019 SHALL implement a two-state FSM, IDLE and LOCK.
REQ-020 In IDLE with any req_valid high, SHALL pick the first valid requester found by searching upward, with wrap, from rr_ptr, load grant_id, and enter LOCK on the next edge. No beat is accepted in the arbitration cycle.
REQ-021 In IDLE with no req_valid high, SHALL remain in IDLE.
REQ-022 SHALL drive req_ready[grant_id] = busy & ~wfull and all other req_ready bits to 0; this is combinational from registered state.
REQ-023 A beat SHALL be accepted when req_valid[grant_id] & req_ready[grant_id]; in that cycle wen=1, waddr=wbin[ASIZE-1:0], wdata=req_data of grant_id (all combinational).
REQ-024 wen SHALL be 0 in every cycle that does not accept a beat.
REQ-025 On an accepted beat, wbin (ASIZE+1 bits) SHALL increment modulo 2^(ASIZE+1); wptr SHALL update on the same edge to (wbin_next>>1)^wbin_next.
REQ-026 On an accepted beat with req_last[grant_id]=1, SHALL return to IDLE and set rr_ptr = (grant_id+1) mod NREQ.
REQ-027 SHALL hold LOCK across gaps in req_valid and across wfull stalls until the last beat is accepted; other requesters are never granted mid-burst.
REQ-028 wfull SHALL register (wgray_next == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]}), where wgray_next is the Gray form of the post-increment pointer.
REQ-029 wlevel SHALL register wbin_next - gray2bin(wq2_rptr), modulo 2^(ASIZE+1).
REQ-030 Read-side frees are visible only through wq2_rptr; full/level SHALL be pessimistic and never optimistic.
REQ-031 On wrap-around (wbin 31->0 for ASIZE=4), full and level SHALL remain correct via the extra MSB.

Reset
REQ-032 While wrst_n=0: state=IDLE, busy=0, grant_id=0, rr_ptr=0, wbin=0, wptr=0, wfull=0, wlevel=0, wen=0, req_ready=0.
REQ-033 Reset asserted mid-burst SHALL abandon the burst immediately; after release, arbitration SHALL restart from requester 0.

Verification
REQ-034 Single requester: req 2 sends 3 beats, last on beat 3, with wq2_rptr=0 -> grant_id=2 after 1 cycle; wen on 3 consecutive cycles; waddr 0,1,2; wptr=00010b; wlevel=3; back to IDLE; rr_ptr=3.
REQ-035 Round robin: reqs 0 and 1 send continuous 1-beat bursts -> grants alternate 0,1,0,1 with one idle arbitration cycle between bursts.
REQ-036 Fill: req 0 streams 16 beats with wq2_rptr held 0 -> wfull=1 after the 16th accept; req_ready=0; wlevel=16; a further valid beat is stalled with no wen.
REQ-037 Drain release: from full, drive wq2_rptr to Gray(4)=00110b -> wfull clears the next cycle; 4 more beats are accepted; wfull reasserts.
REQ-038 Wrap: 40 beats written with the reader tracking behind -> waddr wraps 15->0; wptr sequence is valid Gray with one-bit changes; no false full.
REQ-039 Reset mid-burst: assert wrst_n=0 during beat 2 of 5 -> all outputs reach their reset values at once; after release, req 3 and req 0 both valid -> req 0 is granted.

Source files
------------

// File: rtl/async_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_arb
//   Write side of an asynchronous FIFO fed by NREQ burst requesters through a
//   round-robin arbiter. Once a requester is granted it keeps the FIFO write
//   port until its last beat is accepted. The block keeps the binary and Gray
//   write pointers, and derives full and level from the read pointer that has
//   already been synchronized into wclk.
//
// Parameters
//   ASIZE : FIFO address width (depth = 2**ASIZE)
//   DSIZE : data width
//   NREQ  : number of requesters, 2..8
//
// Ports
//   wclk, wrst_n          : write clock, asynchronous active-low reset
//   req_valid/last/data   : per-requester beat valid, last-of-burst, data
//                           (requester i uses req_data[i*DSIZE +: DSIZE])
//   req_ready             : per-requester beat accept (only the granted one)
//   wq2_rptr              : Gray read pointer, synchronized into wclk
//   wen/waddr/wdata       : FIFO RAM write port
//   wptr                  : registered Gray write pointer to the read side
//   wfull                 : registered full flag
//   wlevel                : registered occupancy estimate, 0..2**ASIZE
//   grant_id, busy        : locked requester index, burst-locked flag
// -----------------------------------------------------------------------------
module async_fifo_wr_arb #(
    parameter int ASIZE = 4,
    parameter int DSIZE = 32,
    parameter int NREQ  = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic [ASIZE:0]        wq2_rptr,
    output logic                  wen,
    output logic [ASIZE-1:0]      waddr,
    output logic [DSIZE-1:0]      wdata,
    output logic [ASIZE:0]        wptr,
    output logic                  wfull,
    output logic [ASIZE:0]        wlevel,
    output logic [2:0]            grant_id,
    output logic                  busy
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q,    state_d;
    logic [2:0]      grant_id_q, grant_id_d;
    logic [2:0]      rr_ptr_q,   rr_ptr_d;
    logic [ASIZE:0]  wbin_q,     wbin_d;
    logic [ASIZE:0]  wptr_q,     wptr_d;
    logic [ASIZE:0]  wlevel_q,   wlevel_d;
    logic            wfull_q,    wfull_d;

    logic             sel_valid;
    logic             sel_last;
    logic [DSIZE-1:0] sel_data;
    logic             accept;
    logic [NREQ-1:0]  rot_valid;
    logic             found;
    logic [2:0]       pick;
    logic [3:0]       pick_sum;
    logic [ASIZE:0]   rbin;

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int unsigned i = 0; i < ASIZE; i++) begin
            b[ASIZE-1-i] = b[ASIZE-i] ^ g[ASIZE-1-i];
        end
        return b;
    endfunction

    assign busy = (state_q == LOCK);

    // Granted requester's signals, selected by comparison so the 3-bit
    // grant index never indexes a narrower vector directly.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id_q == 3'(i)) begin
                sel_valid    = req_valid[i];
                sel_last     = req_last[i];
                sel_data     = req_data[i*DSIZE +: DSIZE];
                req_ready[i] = busy & ~wfull_q;
            end
        end
    end

    assign accept = busy & ~wfull_q & sel_valid;
    assign wen    = accept;
    assign waddr  = wbin_q[ASIZE-1:0];
    assign wdata  = sel_data;

    // Round-robin search: rotate the valid vector so rr_ptr lands on bit 0,
    // take the lowest set bit, then map that offset back to a requester.
    always_comb begin
        rot_valid = NREQ'({req_valid, req_valid} >> rr_ptr_q);
        found     = 1'b0;
        pick      = rr_ptr_q;
        pick_sum  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && rot_valid[i]) begin
                found    = 1'b1;
                pick_sum = {1'b0, rr_ptr_q} + 4'(i);
                if (pick_sum >= 4'(NREQ)) begin
                    pick_sum = pick_sum - 4'(NREQ);
                end
                pick = pick_sum[2:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;

        wbin_d   = accept ? (wbin_q + 1'b1) : wbin_q;
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        rbin     = gray2bin(wq2_rptr);
        // Full when the next write pointer has lapped the read pointer once:
        // top two Gray bits inverted, the rest equal.
        wfull_d  = (wptr_d == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});
        wlevel_d = wbin_d - rbin;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_id_d = pick;
                    state_d    = LOCK;
                end
            end
            LOCK: begin
                if (accept && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_id_q == 3'(NREQ-1)) ? 3'd0 : (grant_id_q + 3'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            wbin_q     <= '0;
            wptr_q     <= '0;
            wfull_q    <= 1'b0;
            wlevel_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            wbin_q     <= wbin_d;
            wptr_q     <= wptr_d;
            wfull_q    <= wfull_d;
            wlevel_q   <= wlevel_d;
        end
    end

    assign grant_id = grant_id_q;
    assign wptr     = wptr_q;
    assign wfull    = wfull_q;
    assign wlevel   = wlevel_q;

endmodule
